// File: rtl/stream_mux_n_pkg.sv
// Shared encodings for the N-input packet stream multiplexer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package stream_mux_n_pkg;

  // Selection policy.
  localparam int MODE_SEL = 0;  // external sel picks the channel
  localparam int MODE_RR  = 1;  // round-robin between requesting channels

  // Grant FSM: IDLE picks a new candidate per beat, LOCKED holds the grant
  // until the current packet's last beat is accepted.
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  // Channel-index width, never below one bit.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter_n.sv
// Round-robin pick: first requesting channel strictly after ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; caller decides whether the pick is consumed.
// Ports: req (request vector), ptr (last served channel),
//        gnt_idx/gnt_vld (chosen channel, valid when any request is set).
module rr_arbiter_n #(
  parameter int N  = 4,
  parameter int SW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic [SW-1:0] gnt_idx,
  output logic          gnt_vld
);

  logic [SW-1:0] idx;

  // Walk offsets from farthest to nearest so the nearest requester after
  // ptr is the last one written and therefore wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = '0;
    for (int off = N; off >= 1; off--) begin
      idx = SW'((int'(ptr) + off) % N);
      if (req[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = idx;
      end
    end
  end

endmodule

// File: rtl/stream_mux_n.sv
// Packet-aware N:1 stream mux; a packet is never interleaved with another.
// Latency: one cycle from input accept to registered output beat.
// Backpressure: in_ready follows out_ready combinationally, no skid buffer.
// Ports: clk, rst_n (async active-low); sel (MODE_SEL channel select);
//        in_data/in_valid/in_last/in_ready (N packed channels);
//        out_data/out_valid/out_last/out_chan/out_ready (single output).
module stream_mux_n
  import stream_mux_n_pkg::*;
#(
  parameter int  W    = 32,
  parameter int  N    = 4,
  parameter int  MODE = MODE_SEL,
  localparam int SW   = sel_width(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [SW-1:0] sel,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]  in_valid,
  input  logic [N-1:0]  in_last,
  output logic [N-1:0]  in_ready,
  output logic [W-1:0]  out_data,
  output logic          out_valid,
  output logic          out_last,
  output logic [SW-1:0] out_chan,
  input  logic          out_ready
);

  state_t        state, state_nxt;
  logic [SW-1:0] grant;          // channel owning the packet in progress
  logic          cand_vld;
  logic [SW-1:0] cand_idx;
  logic          gnt_vld;
  logic [SW-1:0] gnt_idx;
  logic          can_take;       // output register free this cycle
  logic          acc;            // a beat is accepted this cycle
  logic          acc_last;
  logic [W-1:0]  acc_data;
  logic [W-1:0]  in_arr [N];

  for (genvar i = 0; i < N; i++) begin : g_unpack
    assign in_arr[i] = in_data[i*W +: W];
  end

  // Candidate channel while IDLE.
  if (MODE == MODE_RR) begin : g_rr
    logic [SW-1:0] rr_ptr;

    // Pointer sits on the last channel that completed a packet; reset to
    // N-1 so channel 0 is served first.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rr_ptr <= SW'(N - 1);
      end else if (acc && acc_last) begin
        rr_ptr <= gnt_idx;
      end
    end

    rr_arbiter_n #(.N(N), .SW(SW)) u_arb (
      .req     (in_valid),
      .ptr     (rr_ptr),
      .gnt_idx (cand_idx),
      .gnt_vld (cand_vld)
    );
  end else begin : g_sel
    // An out-of-range select offers no candidate at all.
    assign cand_vld = (int'(sel) < N);
    assign cand_idx = sel;
  end

  always_comb begin
    gnt_vld = cand_vld;
    gnt_idx = cand_idx;
    if (state == ST_LOCKED) begin
      gnt_vld = 1'b1;
      gnt_idx = grant;
    end
  end

  assign can_take = !out_valid || out_ready;

  // rst_n gating keeps in_ready quiet while reset is held, even though the
  // select path alone could otherwise offer a channel.
  always_comb begin
    in_ready = '0;
    if (rst_n && gnt_vld && can_take) begin
      in_ready[gnt_idx] = 1'b1;
    end
  end

  assign acc      = |(in_ready & in_valid);
  assign acc_last = in_last[gnt_idx];
  assign acc_data = in_arr[gnt_idx];

  // Grant FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (acc && !acc_last) state_nxt = ST_LOCKED;
      ST_LOCKED: if (acc && acc_last)  state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Re-loading on every accept is harmless in LOCKED (same channel) and
  // captures the new owner in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant <= '0;
    end else if (acc) begin
      grant <= gnt_idx;
    end
  end

  // Output register: load on accept, drop valid once drained, else hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
    end else if (acc) begin
      out_valid <= 1'b1;
      out_last  <= acc_last;
      out_data  <= acc_data;
      out_chan  <= gnt_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_mux_n.sv
// Bench for stream_mux_n: select mode, round-robin mode and a 3-channel
// instance, with directed scenarios plus a randomized packet scoreboard.
// Outputs are sampled on the falling edge; inputs change 1 time unit after
// the rising edge.
module tb_stream_mux_n;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  // DUT a: MODE=0, N=4
  logic [1:0]   a_sel = '0;
  logic [127:0] a_in_data = '0;
  logic [3:0]   a_in_valid = '0, a_in_last = '0, a_in_ready;
  logic [31:0]  a_out_data;
  logic         a_out_valid, a_out_last, a_out_ready = 1'b1;
  logic [1:0]   a_out_chan;

  // DUT b: MODE=1, N=4
  logic [1:0]   b_sel = '0;
  logic [127:0] b_in_data = '0;
  logic [3:0]   b_in_valid = '0, b_in_last = '0, b_in_ready;
  logic [31:0]  b_out_data;
  logic         b_out_valid, b_out_last, b_out_ready = 1'b1;
  logic [1:0]   b_out_chan;

  // DUT c: MODE=0, N=3
  logic [1:0]   c_sel = '0;
  logic [95:0]  c_in_data = '0;
  logic [2:0]   c_in_valid = '0, c_in_last = '0, c_in_ready;
  logic [31:0]  c_out_data;
  logic         c_out_valid, c_out_last, c_out_ready = 1'b1;
  logic [1:0]   c_out_chan;

  stream_mux_n #(.W(32), .N(4), .MODE(0)) u_a (
    .clk(clk), .rst_n(rst_n), .sel(a_sel), .in_data(a_in_data),
    .in_valid(a_in_valid), .in_last(a_in_last), .in_ready(a_in_ready),
    .out_data(a_out_data), .out_valid(a_out_valid), .out_last(a_out_last),
    .out_chan(a_out_chan), .out_ready(a_out_ready));

  stream_mux_n #(.W(32), .N(4), .MODE(1)) u_b (
    .clk(clk), .rst_n(rst_n), .sel(b_sel), .in_data(b_in_data),
    .in_valid(b_in_valid), .in_last(b_in_last), .in_ready(b_in_ready),
    .out_data(b_out_data), .out_valid(b_out_valid), .out_last(b_out_last),
    .out_chan(b_out_chan), .out_ready(b_out_ready));

  stream_mux_n #(.W(32), .N(3), .MODE(0)) u_c (
    .clk(clk), .rst_n(rst_n), .sel(c_sel), .in_data(c_in_data),
    .in_valid(c_in_valid), .in_last(c_in_last), .in_ready(c_in_ready),
    .out_data(c_out_data), .out_valid(c_out_valid), .out_last(c_out_last),
    .out_chan(c_out_chan), .out_ready(c_out_ready));

  int b_rr = 3;  // last channel that finished a packet on DUT b

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a_in_valid = 4'hF;
    b_in_valid = 4'hF;
    b_in_last  = 4'hF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_chk++; if (a_out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", a_out_valid); else n_pass++;
    n_chk++; if (a_out_data !== 32'h0) $display("FAIL rst_out_data: got %h want 0", a_out_data); else n_pass++;
    n_chk++; if (a_out_last !== 1'b0) $display("FAIL rst_out_last: got %b want 0", a_out_last); else n_pass++;
    n_chk++; if (a_out_chan !== 2'd0) $display("FAIL rst_out_chan: got %0d want 0", a_out_chan); else n_pass++;
    n_chk++; if (b_out_valid !== 1'b0) $display("FAIL rst_rr_out_valid: got %b want 0", b_out_valid); else n_pass++;
    n_chk++; if (a_in_ready !== 4'b0000) $display("FAIL rst_sel_in_ready: got %b want 0000", a_in_ready); else n_pass++;
    n_chk++; if (b_in_ready !== 4'b0000) $display("FAIL rst_rr_in_ready: got %b want 0000", b_in_ready); else n_pass++;
    rst_n = 1'b1;
    #1;
    n_chk++; if (b_in_ready !== 4'b0001) $display("FAIL rst_rr_first_grant: got %b want 0001", b_in_ready); else n_pass++;
    n_chk++; if (a_in_ready !== 4'b0001) $display("FAIL rst_sel_grant: got %b want 0001", a_in_ready); else n_pass++;
    a_in_valid = '0;
    b_in_valid = '0;
    b_in_last  = '0;
  endtask

  task automatic test_sel_basic();
    cyc();
    a_sel = 2'd2;
    a_in_valid = 4'b0100;
    a_in_last  = 4'b0100;
    a_in_data[64 +: 32] = 32'hDEADBEEF;
    a_out_ready = 1'b1;
    @(negedge clk);
    n_chk++; if (a_in_ready !== 4'b0100) $display("FAIL sel_in_ready: got %b want 0100", a_in_ready); else n_pass++;
    cyc();
    a_in_valid = '0;
    a_in_last  = '0;
    @(negedge clk);
    n_chk++; if (a_out_valid !== 1'b1) $display("FAIL sel_out_valid: got %b want 1", a_out_valid); else n_pass++;
    n_chk++; if (a_out_data !== 32'hDEADBEEF) $display("FAIL sel_out_data: got %h want deadbeef", a_out_data); else n_pass++;
    n_chk++; if (a_out_chan !== 2'd2) $display("FAIL sel_out_chan: got %0d want 2", a_out_chan); else n_pass++;
    n_chk++; if (a_out_last !== 1'b1) $display("FAIL sel_out_last: got %b want 1", a_out_last); else n_pass++;
    cyc();
    @(negedge clk);
    n_chk++; if (a_out_valid !== 1'b0) $display("FAIL sel_drain_valid: got %b want 0", a_out_valid); else n_pass++;
  endtask

  task automatic test_lock();
    cyc();
    a_sel = 2'd1;
    a_in_valid = 4'b1010;
    a_in_last  = 4'b1000;
    a_in_data[32 +: 32] = 32'h0000_00A1;
    a_in_data[96 +: 32] = 32'h0000_00C3;
    @(negedge clk);
    n_chk++; if (a_in_ready !== 4'b0010) $display("FAIL lock_a1_ready: got %b want 0010", a_in_ready); else n_pass++;
    cyc();
    a_sel = 2'd3;
    a_in_data[32 +: 32] = 32'h0000_00A2;
    @(negedge clk);
    n_chk++; if (a_in_ready !== 4'b0010) $display("FAIL lock_a2_ready: got %b want 0010", a_in_ready); else n_pass++;
    n_chk++; if (a_out_data !== 32'hA1 || a_out_chan !== 2'd1) $display("FAIL lock_a1_out: got %h/%0d want a1/1", a_out_data, a_out_chan); else n_pass++;
    cyc();
    a_in_data[32 +: 32] = 32'h0000_00A3;
    a_in_last = 4'b1010;
    @(negedge clk);
    n_chk++; if (a_in_ready !== 4'b0010) $display("FAIL lock_a3_ready: got %b want 0010", a_in_ready); else n_pass++;
    n_chk++; if (a_out_data !== 32'hA2 || a_out_chan !== 2'd1) $display("FAIL lock_a2_out: got %h/%0d want a2/1", a_out_data, a_out_chan); else n_pass++;
    cyc();
    a_in_valid = 4'b1000;
    @(negedge clk);
    n_chk++; if (a_in_ready !== 4'b1000) $display("FAIL lock_release_ready: got %b want 1000", a_in_ready); else n_pass++;
    n_chk++; if (a_out_data !== 32'hA3 || a_out_last !== 1'b1 || a_out_chan !== 2'd1) $display("FAIL lock_a3_out: got %h/%b/%0d want a3/1/1", a_out_data, a_out_last, a_out_chan); else n_pass++;
    cyc();
    a_in_valid = '0;
    a_in_last  = '0;
    @(negedge clk);
    n_chk++; if (a_out_data !== 32'hC3 || a_out_chan !== 2'd3) $display("FAIL lock_c3_out: got %h/%0d want c3/3", a_out_data, a_out_chan); else n_pass++;
    cyc();
  endtask

  task automatic test_backpressure();
    a_sel = 2'd0;
    a_in_valid = 4'b0001;
    a_in_last  = 4'b0001;
    a_in_data[0 +: 32] = 32'hB0B0_0000;
    a_out_ready = 1'b1;
    cyc();
    a_in_data[0 +: 32] = 32'hB0B0_0001;
    a_out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_chk++; if (a_out_valid !== 1'b1 || a_out_data !== 32'hB0B0_0000 || a_out_chan !== 2'd0 || a_out_last !== 1'b1)
        $display("FAIL bp_hold_%0d: got v%b %h ch%0d l%b want v1 b0b00000 ch0 l1", k, a_out_valid, a_out_data, a_out_chan, a_out_last);
      else n_pass++;
      n_chk++; if (a_in_ready !== 4'b0000) $display("FAIL bp_ready_%0d: got %b want 0000", k, a_in_ready); else n_pass++;
      cyc();
    end
    a_out_ready = 1'b1;
    @(negedge clk);
    n_chk++; if (a_in_ready !== 4'b0001) $display("FAIL bp_release_ready: got %b want 0001", a_in_ready); else n_pass++;
    n_chk++; if (a_out_data !== 32'hB0B0_0000) $display("FAIL bp_release_data: got %h want b0b00000", a_out_data); else n_pass++;
    cyc();
    a_in_valid = '0;
    a_in_last  = '0;
    @(negedge clk);
    n_chk++; if (a_out_valid !== 1'b1 || a_out_data !== 32'hB0B0_0001) $display("FAIL bp_next_beat: got v%b %h want v1 b0b00001", a_out_valid, a_out_data); else n_pass++;
    cyc();
  endtask

  task automatic test_rr();
    cyc();
    b_out_ready = 1'b1;
    b_in_valid = 4'hF;
    b_in_last  = 4'hF;
    for (int i = 0; i < 4; i++) b_in_data[i*32 +: 32] = 32'hC0DE_0000 + i;
    for (int k = 0; k < 6; k++) begin
      cyc();
      b_rr = (b_rr + 1) % 4;
      @(negedge clk);
      n_chk++; if (b_out_valid !== 1'b1 || b_out_chan !== 2'(b_rr) || b_out_data !== 32'hC0DE_0000 + b_rr)
        $display("FAIL rr_seq_%0d: got v%b ch%0d %h want v1 ch%0d", k, b_out_valid, b_out_chan, b_out_data, b_rr);
      else n_pass++;
    end
    b_in_valid = '0;
    b_in_last  = '0;
  endtask

  task automatic test_reset_midpacket();
    cyc();
    b_in_valid = 4'b0100;
    b_in_last  = 4'b0000;
    b_in_data[64 +: 32] = 32'h2222_0001;
    @(negedge clk);
    n_chk++; if (b_in_ready !== 4'b0100) $display("FAIL mid_first_ready: got %b want 0100", b_in_ready); else n_pass++;
    cyc();
    b_in_data[64 +: 32] = 32'h2222_0002;
    @(negedge clk);
    n_chk++; if (b_out_valid !== 1'b1 || b_out_chan !== 2'd2) $display("FAIL mid_first_out: got v%b ch%0d want v1 ch2", b_out_valid, b_out_chan); else n_pass++;
    b_in_valid = 4'b0101;
    b_in_last  = 4'b0001;
    b_in_data[0 +: 32] = 32'h0000_00A0;
    #1;
    n_chk++; if (b_in_ready !== 4'b0100) $display("FAIL mid_locked_ready: got %b want 0100", b_in_ready); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_chk++; if (b_out_valid !== 1'b0) $display("FAIL mid_async_valid: got %b want 0", b_out_valid); else n_pass++;
    n_chk++; if (b_in_ready !== 4'b0000) $display("FAIL mid_async_ready: got %b want 0000", b_in_ready); else n_pass++;
    rst_n = 1'b1;
    #1;
    n_chk++; if (b_in_ready !== 4'b0001) $display("FAIL mid_after_rst_ready: got %b want 0001", b_in_ready); else n_pass++;
    cyc();
    b_in_valid = 4'b0100;
    b_in_last  = 4'b0000;
    @(negedge clk);
    n_chk++; if (b_out_chan !== 2'd0 || b_out_data !== 32'hA0) $display("FAIL mid_ch0_out: got ch%0d %h want ch0 a0", b_out_chan, b_out_data); else n_pass++;
    n_chk++; if (b_in_ready !== 4'b0100) $display("FAIL mid_ch2_ready: got %b want 0100", b_in_ready); else n_pass++;
    cyc();
    b_in_data[64 +: 32] = 32'h2222_0003;
    b_in_last = 4'b0100;
    @(negedge clk);
    n_chk++; if (b_out_chan !== 2'd2 || b_out_data !== 32'h2222_0002) $display("FAIL mid_new_pkt_out: got ch%0d %h want ch2 22220002", b_out_chan, b_out_data); else n_pass++;
    cyc();
    b_in_valid = '0;
    b_in_last  = '0;
    @(negedge clk);
    n_chk++; if (b_out_data !== 32'h2222_0003 || b_out_last !== 1'b1) $display("FAIL mid_last_out: got %h l%b want 22220003 l1", b_out_data, b_out_last); else n_pass++;
    cyc();
  endtask

  task automatic test_out_of_range();
    cyc();
    c_sel = 2'd3;
    c_in_valid = 3'b111;
    c_in_last  = 3'b111;
    c_in_data  = {32'h33, 32'h22, 32'h11};
    c_out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_chk++; if (c_in_ready !== 3'b000) $display("FAIL oob_ready_%0d: got %b want 000", k, c_in_ready); else n_pass++;
      n_chk++; if (c_out_valid !== 1'b0) $display("FAIL oob_valid_%0d: got %b want 0", k, c_out_valid); else n_pass++;
      cyc();
    end
    c_sel = 2'd2;
    @(negedge clk);
    n_chk++; if (c_in_ready !== 3'b100) $display("FAIL oob_sel2_ready: got %b want 100", c_in_ready); else n_pass++;
    cyc();
    c_in_valid = '0;
    @(negedge clk);
    n_chk++; if (c_out_valid !== 1'b1 || c_out_chan !== 2'd2 || c_out_data !== 32'h33) $display("FAIL oob_sel2_out: got v%b ch%0d %h want v1 ch2 33", c_out_valid, c_out_chan, c_out_data); else n_pass++;
    cyc();
  endtask

  // Randomized packets on the round-robin instance. The model tracks, per
  // cycle: which channel owns an unfinished input packet, the last channel
  // that completed one, and whether a beat sits in the output stage.
  task automatic test_random();
    logic [32:0] drvq [4][$];
    logic [32:0] expq [4][$];
    logic [32:0] beat;
    logic [3:0]  exp_rdy;
    logic        occ;
    int rr, in_pkt, out_pkt, g, acc_ch, ch, left, c;
    bit gv, can;

    for (int i = 0; i < 4; i++) begin
      for (int p = 0; p < 6; p++) begin
        int len = $urandom_range(4, 1);
        for (int b = 0; b < len; b++) begin
          beat = {(b == len - 1) ? 1'b1 : 1'b0, 32'($urandom)};
          drvq[i].push_back(beat);
          expq[i].push_back(beat);
        end
      end
    end

    rst_n = 1'b0;
    b_in_valid = '0;
    b_in_last  = '0;
    b_out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    rr = 3; in_pkt = -1; out_pkt = -1; occ = 1'b0;

    for (int cy = 0; cy < 4000; cy++) begin
      @(negedge clk);
      can = (occ == 1'b0) || b_out_ready;
      gv = 1'b0; g = 0;
      if (in_pkt >= 0) begin
        gv = 1'b1; g = in_pkt;
      end else begin
        for (int off = 1; off <= 4; off++) begin
          c = (rr + off) % 4;
          if (!gv && b_in_valid[c]) begin gv = 1'b1; g = c; end
        end
      end
      exp_rdy = (can && gv) ? (4'b0001 << g) : 4'b0000;
      n_chk++; if (b_in_ready !== exp_rdy) $display("FAIL rand_in_ready cy%0d: got %b want %b", cy, b_in_ready, exp_rdy); else n_pass++;
      n_chk++; if (b_out_valid !== occ) $display("FAIL rand_out_valid cy%0d: got %b want %b", cy, b_out_valid, occ); else n_pass++;

      if (occ && b_out_ready) begin
        ch = int'(b_out_chan);
        if (out_pkt >= 0) begin
          n_chk++; if (ch != out_pkt) $display("FAIL rand_contig cy%0d: got ch%0d want ch%0d", cy, ch, out_pkt); else n_pass++;
        end
        n_chk++;
        if (expq[ch].size() == 0) begin
          $display("FAIL rand_out_beat cy%0d: got beat on ch%0d want none pending", cy, ch);
          out_pkt = -1;
        end else begin
          beat = expq[ch].pop_front();
          if ({b_out_last, b_out_data} !== beat) $display("FAIL rand_out_beat cy%0d: got l%b %h want l%b %h", cy, b_out_last, b_out_data, beat[32], beat[31:0]);
          else n_pass++;
          out_pkt = beat[32] ? -1 : ch;
        end
        occ = 1'b0;
      end

      acc_ch = -1;
      if ((exp_rdy & b_in_valid) != 4'b0000) begin
        beat = drvq[g].pop_front();
        acc_ch = g;
        if (beat[32]) begin in_pkt = -1; rr = g; end
        else in_pkt = g;
        occ = 1'b1;
      end

      left = 0;
      for (int i = 0; i < 4; i++) left += drvq[i].size() + expq[i].size();
      if (left == 0 && occ == 1'b0) break;

      cyc();
      if (acc_ch >= 0) b_in_valid[acc_ch] = 1'b0;
      b_out_ready = ($urandom_range(3) != 0);
      for (int i = 0; i < 4; i++) begin
        if (!b_in_valid[i] && drvq[i].size() > 0 && $urandom_range(1) == 1) begin
          b_in_valid[i] = 1'b1;
          b_in_data[i*32 +: 32] = drvq[i][0][31:0];
          b_in_last[i] = drvq[i][0][32];
        end
      end
    end

    left = 0;
    for (int i = 0; i < 4; i++) left += drvq[i].size() + expq[i].size();
    n_chk++; if (left != 0) $display("FAIL rand_drain: got %0d beats outstanding want 0", left); else n_pass++;
    b_in_valid = '0;
    b_out_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_sel_basic();
    test_lock();
    test_backpressure();
    test_rr();
    test_reset_midpacket();
    test_out_of_range();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
